codec_i2s_bridge: RTL and testbench



---
 rtl/codec_i2s_bridge.sv | 113 +++++++++++
 tb/tb_codec_i2s_bridge.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/codec_i2s_bridge.sv
// I2S master bridge: divides clk into bclk/lrck, deserializes 24-bit ADC words, serializes DAC words.
// Optional macro CODEC_LOOPBACK_EN adds a loopback input that retransmits the last captured frame.
module codec_i2s_bridge #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adc_dat,
    input  logic [23:0] dac_l,
    input  logic [23:0] dac_r,
`ifdef CODEC_LOOPBACK_EN
    input  logic        loopback,
`endif
    output logic        bclk,
    output logic        lrck,
    output logic        dac_dat,
    output logic [23:0] in_l,
    output logic [23:0] in_r,
    output logic        new_sample
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic [5:0]    slot;
    logic [23:0]   rx_sr;
    logic [23:0]   hold_l;
    logic [23:0]   tx_l;
    logic [23:0]   tx_r;

    logic          tick;
    logic          rise;
    logic          fall;
    logic [5:0]    slot_nx;
    logic [4:0]    k_cur;
    logic [4:0]    k_nx;
    logic [4:0]    bit_idx;
    logic          tx_bit;
    logic [23:0]   src_l;
    logic [23:0]   src_r;

    assign tick    = (div_cnt == DW'(CLK_DIV - 1));
    assign rise    = tick & ~bclk;
    assign fall    = tick & bclk;
    assign slot_nx = slot + 6'd1;
    assign k_cur   = slot[4:0];
    assign k_nx    = slot_nx[4:0];
    assign bit_idx = 5'd24 - k_nx;
    assign lrck    = slot[5];

    // dac_dat is updated on the falling bclk edge with the bit of the slot being entered.
    always_comb begin
        tx_bit = 1'b0;
        if (k_nx >= 5'd1 && k_nx <= 5'd24)
            tx_bit = slot_nx[5] ? tx_r[bit_idx] : tx_l[bit_idx];
    end

    always_comb begin
        src_l = dac_l;
        src_r = dac_r;
`ifdef CODEC_LOOPBACK_EN
        if (loopback) begin
            src_l = in_l;
            src_r = in_r;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            bclk       <= 1'b0;
            slot       <= '0;
            rx_sr      <= '0;
            hold_l     <= '0;
            tx_l       <= '0;
            tx_r       <= '0;
            dac_dat    <= 1'b0;
            in_l       <= '0;
            in_r       <= '0;
            new_sample <= 1'b0;
        end else begin
            new_sample <= 1'b0;
            if (tick) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end

            if (rise && k_cur >= 5'd1 && k_cur <= 5'd24)
                rx_sr <= {rx_sr[22:0], adc_dat};

            if (fall) begin
                slot    <= slot_nx;
                dac_dat <= tx_bit;
                // Left word is parked until the right word completes so both update together.
                if (slot == 6'd24)
                    hold_l <= rx_sr;
                if (slot == 6'd56) begin
                    in_l       <= hold_l;
                    in_r       <= rx_sr;
                    new_sample <= 1'b1;
                end
                if (slot == 6'd63) begin
                    tx_l <= src_l;
                    tx_r <= src_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_codec_i2s_bridge.sv
// Scoreboard bench for codec_i2s_bridge at CLK_DIV=4 and CLK_DIV=1 side by side.
// Timing expectations come from edge counts since reset release; codec data is random per frame.
module tb_codec_i2s_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b1;
    int   e = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // e = number of edges since the last reset edge (state after edge e).
    always @(posedge clk) begin
        rst_q <= rst;
        e     <= rst ? 0 : e + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, e);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int D = (g == 0) ? 4 : 1;

        logic        adc_dat = 1'b0;
        logic [23:0] dac_l = 24'hFFFFFF;
        logic [23:0] dac_r = 24'h800001;
        logic        bclk, lrck, dac_dat, new_sample;
        logic [23:0] in_l, in_r;
        logic [47:0] adc_q[$];
        logic [47:0] dac_q[$];
        logic [47:0] cur_w = '0;
        int          cur_f = -1;
`ifdef CODEC_LOOPBACK_EN
        logic        lb = 1'b0;
`endif

        codec_i2s_bridge #(.CLK_DIV(D)) dut (
            .clk        (clk),
            .rst        (rst),
            .adc_dat    (adc_dat),
            .dac_l      (dac_l),
            .dac_r      (dac_r),
`ifdef CODEC_LOOPBACK_EN
            .loopback   (lb),
`endif
            .bclk       (bclk),
            .lrck       (lrck),
            .dac_dat    (dac_dat),
            .in_l       (in_l),
            .in_r       (in_r),
            .new_sample (new_sample)
        );

        // Stimulus: codec model plus DAC word source; pushes expectations for the edge about to come.
        always @(posedge clk) begin
            int n, s, k, f;
            #2;
            if (rst_q) begin
                adc_q.delete();
                dac_q.delete();
                dac_q.push_back(48'h0);
                cur_f = -1;
            end
            if (!rst) begin
                n = e + 1;
                s = (n / (2 * D)) % 64;
                k = s % 32;
                f = n / (128 * D);
                if (n % (128 * D) == 0) begin
`ifdef CODEC_LOOPBACK_EN
                    lb = 1'($urandom_range(0, 1));
                    if (lb) dac_q.push_back(cur_w);
                    else    dac_q.push_back({dac_l, dac_r});
`else
                    dac_q.push_back({dac_l, dac_r});
`endif
                end else if (f >= 1 && n % (2 * D) == 0 && $urandom_range(0, 31) == 0) begin
                    dac_l = 24'($urandom);
                    dac_r = 24'($urandom);
                end
                if (f != cur_f) begin
                    cur_f = f;
                    cur_w = (f == 0) ? {24'hA5C3F1, 24'h123456} : {24'($urandom), 24'($urandom)};
                    adc_q.push_back(cur_w);
                end
                if (k >= 1 && k <= 24) adc_dat = (s < 32) ? cur_w[48 - k] : cur_w[24 - k];
                else                   adc_dat = 1'b1;
            end
        end

        // Monitor: compares outputs each cycle and pops scoreboard entries as words complete.
        always @(negedge clk) begin
            int s, k, ph;
            logic [47:0] w;
            logic expb;
            if (rst_q) begin
                check($sformatf("D%0d reset_state", D),
                      64'({bclk, lrck, dac_dat, new_sample, in_l, in_r}), 64'h0);
            end else begin
                s  = (e / (2 * D)) % 64;
                k  = s % 32;
                ph = e % (2 * D);
                check($sformatf("D%0d bclk", D), 64'(bclk), 64'((e / D) % 2));
                check($sformatf("D%0d lrck", D), 64'(lrck), 64'(s >= 32));
                check($sformatf("D%0d new_sample", D), 64'(new_sample),
                      64'(e % (128 * D) == 114 * D));
                if (new_sample) begin
                    if (adc_q.size() == 0) begin
                        check($sformatf("D%0d adc_queue_nonempty", D), 64'h0, 64'h1);
                    end else begin
                        w = adc_q.pop_front();
                        check($sformatf("D%0d in_l_in_r", D), 64'({in_l, in_r}), 64'(w));
                    end
                end
                expb = 1'b0;
                if (k >= 1 && k <= 24) begin
                    if (dac_q.size() == 0) begin
                        check($sformatf("D%0d dac_queue_nonempty", D), 64'h0, 64'h1);
                    end else begin
                        w = dac_q[0];
                        expb = (s < 32) ? w[48 - k] : w[24 - k];
                    end
                end
                check($sformatf("D%0d dac_dat slot%0d", D, s), 64'(dac_dat), 64'(expb));
                if (s == 56 && ph == 2 * D - 1 && dac_q.size() != 0)
                    void'(dac_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        // Pulse reset at frame 2, slot 40 of the CLK_DIV=4 instance.
        repeat (1346) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (1600) @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
